// File: rtl/pattern_select_fsm_pkg.sv
// Shared types and default constants for the pattern-select detector and its mux neighbours.
package pattern_select_fsm_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    localparam int                   DEF_PAT_W       = 4;
    localparam logic [DEF_PAT_W-1:0] DEF_PATTERN     = 4'b1011;
    localparam int                   DEF_HOLD_CYCLES = 3;
    localparam int                   DEF_CNT_W       = 8;

endpackage

// File: rtl/pattern_select_fsm_shift_matcher.sv
// Serial shift register with fill tracking; flags a combinational hit on the completing bit.
module pattern_shift_matcher
    import pattern_select_fsm_pkg::*;
#(
    parameter int               PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    input  logic din_valid,
    output logic hit
);

    localparam int FILL_W = $clog2(PAT_W + 1);

    logic [PAT_W-2:0]  shreg_q, shreg_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [PAT_W-1:0]  window_s;

    // Window holds the last PAT_W-1 stored bits plus the bit being offered now.
    assign window_s = {shreg_q, din};

    // Next-state for shift register and saturating fill counter.
    always_comb begin
        shreg_d = shreg_q;
        fill_d  = fill_q;
        if (din_valid) begin
            shreg_d = window_s[PAT_W-2:0];
            if (fill_q != FILL_W'(PAT_W)) begin
                fill_d = fill_q + FILL_W'(1);
            end else begin
                fill_d = fill_q;
            end
        end else begin
            shreg_d = shreg_q;
        end
    end

    // Shift and fill state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg_q <= '0;
            fill_q  <= '0;
        end else begin
            shreg_q <= shreg_d;
            fill_q  <= fill_d;
        end
    end

    // Fill gate keeps reset-cleared zeros from forming a false match.
    assign hit = din_valid & (fill_q >= FILL_W'(PAT_W - 1)) & (window_s == PATTERN);

endmodule

// File: rtl/pattern_select_fsm.sv
// Pattern detector driving a mux select: pulses match, holds sel for a window, counts hits.
module pattern_select_fsm
    import pattern_select_fsm_pkg::*;
#(
    parameter int               PAT_W       = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN     = DEF_PATTERN,
    parameter int               HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int               CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    input  logic             din_valid,
    output logic             sel,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             busy
);

    localparam logic [7:0]       HOLD_RELOAD = 8'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    logic [7:0]       hold_q, hold_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sel_q, sel_d;
    logic             match_q, match_d;
    logic             hit_s;

    pattern_shift_matcher #(
        .PAT_W   (PAT_W),
        .PATTERN (PATTERN)
    ) u_matcher (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .din_valid (din_valid),
        .hit       (hit_s)
    );

    // FSM next-state, hold countdown, saturating counter and output decode.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (hit_s) begin
                    state_d = ST_HOLD;
                    hold_d  = HOLD_RELOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                // A hit on the expiring cycle wins and restarts the window.
                if (hit_s) begin
                    hold_d = HOLD_RELOAD;
                end else if (hold_q == 8'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_d = hold_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                hold_d  = 8'd0;
            end
        endcase
        if (hit_s && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
        sel_d   = (state_d == ST_HOLD);
        match_d = hit_s;
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            hold_q  <= 8'd0;
            cnt_q   <= '0;
            sel_q   <= 1'b0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            match_q <= match_d;
        end
    end

    assign sel         = sel_q;
    assign busy        = sel_q;
    assign match       = match_q;
    assign match_count = cnt_q;

endmodule

// File: tb/tb_pattern_select_fsm.sv
// Self-checking bench: three detector variants share one input stream against a history-based model.
module tb_pattern_select_fsm;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       din = 1'b0;
    logic       din_valid = 1'b0;
    logic       sel0, match0, busy0;
    logic [7:0] cnt0;
    logic       sel1, match1, busy1;
    logic [7:0] cnt1;
    logic       sel2, match2, busy2;
    logic [1:0] cnt2;

    int nchecks = 0;
    int nerr    = 0;

    // Model state per instance: 0 = default, 1 = pattern 0011, 2 = 2-bit counter.
    logic [3:0] pats [3];
    int         maxc [3];
    logic [3:0] hist [3];
    int         seen [3];
    int         age  [3];
    int         mcnt [3];
    bit         mmatch [3];
    bit         msel [3];

    pattern_select_fsm #(.PAT_W(4), .PATTERN(4'b1011), .HOLD_CYCLES(3), .CNT_W(8)) u_dut0 (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .sel(sel0), .match(match0), .match_count(cnt0), .busy(busy0));
    pattern_select_fsm #(.PAT_W(4), .PATTERN(4'b0011), .HOLD_CYCLES(3), .CNT_W(8)) u_dut1 (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .sel(sel1), .match(match1), .match_count(cnt1), .busy(busy1));
    pattern_select_fsm #(.PAT_W(4), .PATTERN(4'b1011), .HOLD_CYCLES(3), .CNT_W(2)) u_dut2 (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .sel(sel2), .match(match2), .match_count(cnt2), .busy(busy2));

    always #5 clk = ~clk;

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            hist[i] = 4'd0; seen[i] = 0; age[i] = 1000; mcnt[i] = 0;
            mmatch[i] = 1'b0; msel[i] = 1'b0;
        end
    endtask

    task automatic do_reset();
        din = 1'b0; din_valid = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        model_clear();
    endtask

    // Drive one cycle, then advance the model from the rules: last 4 real bits, hits, window age.
    task automatic step(input logic d, input logic v);
        bit hit;
        din = d; din_valid = v;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            hit = 1'b0;
            if (v) begin
                hist[i] = {hist[i][2:0], d};
                seen[i]++;
                hit = (seen[i] >= 4) && (hist[i] == pats[i]);
            end
            mmatch[i] = hit;
            age[i] = hit ? 0 : ((age[i] < 1000) ? age[i] + 1 : age[i]);
            msel[i] = (age[i] < 3);
            if (hit && mcnt[i] < maxc[i]) mcnt[i]++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; din = 1'b0; din_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        nchecks++;
        if (sel0 !== 1'b0 || match0 !== 1'b0 || busy0 !== 1'b0 || cnt0 !== 8'd0 || cnt2 !== 2'd0) begin
            nerr++;
            $display("FAIL reset: sel=%b match=%b busy=%b cnt0=%0d cnt2=%0d, required all 0", sel0, match0, busy0, cnt0, cnt2);
        end
        reset = 1'b0;
        model_clear();
    endtask

    task automatic test_basic();
        logic [3:0] bits = 4'b1011;
        int pulses = 0;
        int sel_hi = 0;
        do_reset();
        for (int k = 0; k < 9; k++) begin
            if (k < 4) step(bits[3-k], 1'b1); else step(1'b0, 1'b0);
            pulses += int'(match0);
            sel_hi += int'(sel0);
            nchecks++;
            if (match0 !== mmatch[0] || sel0 !== msel[0] || busy0 !== msel[0] || cnt0 !== 8'(mcnt[0])) begin
                nerr++;
                $display("FAIL basic step %0d: match=%b sel=%b busy=%b cnt=%0d, required match=%b sel=%b cnt=%0d",
                         k, match0, sel0, busy0, cnt0, mmatch[0], msel[0], mcnt[0]);
            end
            if (k == 3) begin
                nchecks++;
                if (match0 !== 1'b1 || sel0 !== 1'b1) begin
                    nerr++;
                    $display("FAIL basic latency: match=%b sel=%b, required 1 1", match0, sel0);
                end
            end
        end
        nchecks++;
        if (pulses != 1 || sel_hi != 3 || cnt0 !== 8'd1) begin
            nerr++;
            $display("FAIL basic totals: pulses=%0d sel_cycles=%0d cnt=%0d, required 1 3 1", pulses, sel_hi, cnt0);
        end
    endtask

    task automatic test_overlap();
        logic [6:0] bits = 7'b1011011;
        int first = -1;
        int second = -1;
        int last_sel = -1;
        bit gap = 1'b0;
        do_reset();
        for (int k = 0; k < 12; k++) begin
            if (k < 7) step(bits[6-k], 1'b1); else step(1'b0, 1'b0);
            if (match0 === 1'b1) begin
                if (first < 0) first = k; else second = k;
            end
            if (sel0 === 1'b1) begin
                if (last_sel >= 0 && last_sel != k - 1) gap = 1'b1;
                last_sel = k;
            end
            nchecks++;
            if (match0 !== mmatch[0] || sel0 !== msel[0] || cnt0 !== 8'(mcnt[0])) begin
                nerr++;
                $display("FAIL overlap step %0d: match=%b sel=%b cnt=%0d, required match=%b sel=%b cnt=%0d",
                         k, match0, sel0, cnt0, mmatch[0], msel[0], mcnt[0]);
            end
        end
        nchecks++;
        if (first != 3 || second != 6 || gap || last_sel != 8 || cnt0 !== 8'd2) begin
            nerr++;
            $display("FAIL overlap totals: pulses at %0d,%0d gap=%b last_sel=%0d cnt=%0d, required 3,6 0 8 2",
                     first, second, gap, last_sel, cnt0);
        end
    endtask

    task automatic test_valid_gaps();
        logic [3:0] bits = 4'b1011;
        int pulses = 0;
        do_reset();
        for (int b = 0; b < 4; b++) begin
            int gaps = $urandom_range(3, 0);
            for (int g = 0; g < gaps; g++) begin
                step(1'($urandom_range(1, 0)), 1'b0);
                pulses += int'(match0);
            end
            step(bits[3-b], 1'b1);
            pulses += int'(match0);
            nchecks++;
            if (match0 !== mmatch[0] || match0 !== (b == 3)) begin
                nerr++;
                $display("FAIL gaps bit %0d: match=%b, required %b", b, match0, (b == 3));
            end
        end
        step(1'b0, 1'b0);
        nchecks++;
        if (pulses != 1 || match0 !== 1'b0 || cnt0 !== 8'd1) begin
            nerr++;
            $display("FAIL gaps totals: pulses=%0d match=%b cnt=%0d, required 1 0 1", pulses, match0, cnt0);
        end
    endtask

    task automatic test_fill_gate();
        logic [5:0] bits = 6'b110011;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            step(bits[5-k], 1'b1);
            nchecks++;
            if (match1 !== mmatch[1] || match1 !== (k == 5) || cnt1 !== 8'(mcnt[1])) begin
                nerr++;
                $display("FAIL fill_gate bit %0d: match=%b cnt=%0d, required match=%b cnt=%0d",
                         k, match1, cnt1, (k == 5), mcnt[1]);
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        logic [3:0] bits = 4'b1011;
        int pulses = 0;
        do_reset();
        for (int k = 0; k < 4; k++) step(bits[3-k], 1'b1);
        step(1'b0, 1'b0);
        nchecks++;
        if (sel0 !== 1'b1 || cnt0 !== 8'd1) begin
            nerr++;
            $display("FAIL mid_hold pre: sel=%b cnt=%0d, required 1 1", sel0, cnt0);
        end
        #2 reset = 1'b1;
        #1;
        nchecks++;
        if (sel0 !== 1'b0 || busy0 !== 1'b0 || match0 !== 1'b0 || cnt0 !== 8'd0) begin
            nerr++;
            $display("FAIL mid_hold async: sel=%b busy=%b match=%b cnt=%0d, required all 0", sel0, busy0, match0, cnt0);
        end
        #1 reset = 1'b0;
        model_clear();
        step(1'b0, 1'b1); pulses += int'(match0);
        step(1'b1, 1'b1); pulses += int'(match0);
        step(1'b1, 1'b1); pulses += int'(match0);
        nchecks++;
        if (pulses != 0 || cnt0 !== 8'd0 || sel0 !== 1'b0) begin
            nerr++;
            $display("FAIL mid_hold refill: pulses=%0d cnt=%0d sel=%b, required 0 0 0", pulses, cnt0, sel0);
        end
    endtask

    task automatic test_saturation();
        logic [3:0] bits = 4'b1011;
        int pulses = 0;
        do_reset();
        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < 4; k++) begin
                step(bits[3-k], 1'b1);
                pulses += int'(match2);
            end
            nchecks++;
            if (cnt2 !== 2'((r + 1 > 3) ? 3 : r + 1) || match2 !== 1'b1) begin
                nerr++;
                $display("FAIL saturation round %0d: cnt=%0d match=%b, required %0d 1",
                         r, cnt2, match2, (r + 1 > 3) ? 3 : r + 1);
            end
        end
        nchecks++;
        if (pulses != 5) begin
            nerr++;
            $display("FAIL saturation pulses: %0d, required 5", pulses);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 300; k++) begin
            step(1'($urandom_range(1, 0)), ($urandom_range(9, 0) < 7));
            nchecks++;
            if (match0 !== mmatch[0] || sel0 !== msel[0] || busy0 !== msel[0] || cnt0 !== 8'(mcnt[0]) ||
                match1 !== mmatch[1] || sel1 !== msel[1] || cnt1 !== 8'(mcnt[1]) ||
                match2 !== mmatch[2] || sel2 !== msel[2] || cnt2 !== 2'(mcnt[2])) begin
                nerr++;
                $display("FAIL random step %0d: m=%b%b%b s=%b%b%b c=%0d,%0d,%0d, required m=%b%b%b s=%b%b%b c=%0d,%0d,%0d",
                         k, match0, match1, match2, sel0, sel1, sel2, cnt0, cnt1, cnt2,
                         mmatch[0], mmatch[1], mmatch[2], msel[0], msel[1], msel[2], mcnt[0], mcnt[1], mcnt[2]);
            end
        end
    endtask

    initial begin
        pats[0] = 4'b1011; pats[1] = 4'b0011; pats[2] = 4'b1011;
        maxc[0] = 255;     maxc[1] = 255;     maxc[2] = 3;
        model_clear();
        test_reset();
        test_basic();
        test_overlap();
        test_valid_gaps();
        test_fill_gate();
        test_reset_mid_hold();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
